// File: rtl/bsg_axil_initiator_pkg.sv
// Shared types and constants for the AXI4-Lite initiator.
//   state_e          : initiator FSM states
//   resp_*_lp        : AXI response codes
//   prot_default_lp  : protection bits driven on AW/AR
package bsg_axil_initiator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR_DATA,
    WRESP,
    RADDR,
    RDATA,
    RESP
  } state_e;

  localparam logic [1:0] resp_okay_lp   = 2'b00;
  localparam logic [1:0] resp_exokay_lp = 2'b01;
  localparam logic [1:0] resp_slverr_lp = 2'b10;
  localparam logic [1:0] resp_decerr_lp = 2'b11;

  localparam logic [2:0] prot_default_lp = 3'b000;

endpackage

// File: rtl/bsg_axil_dpi_initiator.sv
// AXI4-Lite manager driven by a simple host command port. One command (read or
// write) is accepted at a time, the matching AXI-Lite channels are driven, and the
// response is returned on a valid/ready port. One outstanding transaction.
//
// Ports
//   clk_i, reset_i                     clock, synchronous active-high reset
//   v_i/ready_and_o, w_i, addr_i,      command port (ready only in IDLE)
//   data_i, wstrb_i
//   v_o/ready_and_i, data_o, resp_o    response port (resp 11 on timeout)
//   aw*/w*/b*                          AXI-Lite write channels
//   ar*/r*                             AXI-Lite read channels
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | ready_and_o high, waiting for a command
// WADDR_DATA | AW and W presented, each retired on its own handshake
// WRESP      | bready_o high, waiting for bvalid_i
// RADDR      | arvalid_o high, waiting for arready_i
// RDATA      | rready_o high, waiting for rvalid_i
// RESP       | v_o high, holding data_o/resp_o until ready_and_i
module bsg_axil_dpi_initiator
  import bsg_axil_initiator_pkg::*;
#(
  parameter int addr_width_p = 32,  // must be overridden to match the fabric
  parameter int data_width_p = 32,  // must be overridden; 32 or 64
  parameter int timeout_p    = 0,   // stall cycles before abort; 0 = never
  localparam int strb_width_lp  = data_width_p / 8
)(
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     v_i,
  output logic                     ready_and_o,
  input  logic                     w_i,
  input  logic [addr_width_p-1:0]  addr_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic [strb_width_lp-1:0] wstrb_i,

  output logic                     v_o,
  input  logic                     ready_and_i,
  output logic [data_width_p-1:0]  data_o,
  output logic [1:0]               resp_o,

  output logic [addr_width_p-1:0]  awaddr_o,
  output logic [2:0]               awprot_o,
  output logic                     awvalid_o,
  input  logic                     awready_i,

  output logic [data_width_p-1:0]  wdata_o,
  output logic [strb_width_lp-1:0] wstrb_o,
  output logic                     wvalid_o,
  input  logic                     wready_i,

  input  logic [1:0]               bresp_i,
  input  logic                     bvalid_i,
  output logic                     bready_o,

  output logic [addr_width_p-1:0]  araddr_o,
  output logic [2:0]               arprot_o,
  output logic                     arvalid_o,
  input  logic                     arready_i,

  input  logic [data_width_p-1:0]  rdata_i,
  input  logic [1:0]               rresp_i,
  input  logic                     rvalid_i,
  output logic                     rready_o
);

  localparam int timer_width_lp = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
  localparam logic [timer_width_lp-1:0] timer_limit_lp = timer_width_lp'(timeout_p);

  state_e                    state_r;
  logic [timer_width_lp-1:0] timer_r;
  logic [timer_width_lp-1:0] timer_inc;
  logic                      timer_expire;
  logic                      aw_done, w_done;

  assign awprot_o = prot_default_lp;
  assign arprot_o = prot_default_lp;

  // A channel whose valid is already low was retired on an earlier cycle.
  assign aw_done = ~awvalid_o | awready_i;
  assign w_done  = ~wvalid_o  | wready_i;

  // Saturating stall counter; with timeout disabled the limit is 0 and it never moves.
  assign timer_inc    = (timer_r == timer_limit_lp) ? timer_r : timer_r + timer_width_lp'(1);
  assign timer_expire = (timeout_p > 0) && (timer_inc == timer_limit_lp);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      timer_r     <= '0;
      ready_and_o <= 1'b0;
      v_o         <= 1'b0;
      data_o      <= '0;
      resp_o      <= resp_okay_lp;
      awaddr_o    <= '0;
      awvalid_o   <= 1'b0;
      wdata_o     <= '0;
      wstrb_o     <= '0;
      wvalid_o    <= 1'b0;
      bready_o    <= 1'b0;
      araddr_o    <= '0;
      arvalid_o   <= 1'b0;
      rready_o    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (v_i && ready_and_o) begin
            ready_and_o <= 1'b0;
            timer_r     <= '0;
            if (w_i) begin
              awaddr_o  <= addr_i;
              wdata_o   <= data_i;
              wstrb_o   <= wstrb_i;
              awvalid_o <= 1'b1;
              wvalid_o  <= 1'b1;
              state_r   <= WADDR_DATA;
            end else begin
              araddr_o  <= addr_i;
              arvalid_o <= 1'b1;
              state_r   <= RADDR;
            end
          end else begin
            ready_and_o <= 1'b1;
          end
        end

        WADDR_DATA: begin
          if (awready_i) awvalid_o <= 1'b0;
          if (wready_i)  wvalid_o  <= 1'b0;
          if (aw_done && w_done) begin
            bready_o <= 1'b1;
            timer_r  <= '0;
            state_r  <= WRESP;
          end else if (timer_expire) begin
            awvalid_o <= 1'b0;
            wvalid_o  <= 1'b0;
            data_o    <= '0;
            resp_o    <= resp_decerr_lp;
            v_o       <= 1'b1;
            state_r   <= RESP;
          end else begin
            timer_r <= timer_inc;
          end
        end

        WRESP: begin
          if (bvalid_i) begin
            bready_o <= 1'b0;
            data_o   <= '0;
            resp_o   <= bresp_i;
            v_o      <= 1'b1;
            state_r  <= RESP;
          end else if (timer_expire) begin
            bready_o <= 1'b0;
            data_o   <= '0;
            resp_o   <= resp_decerr_lp;
            v_o      <= 1'b1;
            state_r  <= RESP;
          end else begin
            timer_r <= timer_inc;
          end
        end

        RADDR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            timer_r   <= '0;
            state_r   <= RDATA;
          end else if (timer_expire) begin
            arvalid_o <= 1'b0;
            data_o    <= '0;
            resp_o    <= resp_decerr_lp;
            v_o       <= 1'b1;
            state_r   <= RESP;
          end else begin
            timer_r <= timer_inc;
          end
        end

        RDATA: begin
          if (rvalid_i) begin
            rready_o <= 1'b0;
            data_o   <= rdata_i;
            resp_o   <= rresp_i;
            v_o      <= 1'b1;
            state_r  <= RESP;
          end else if (timer_expire) begin
            rready_o <= 1'b0;
            data_o   <= '0;
            resp_o   <= resp_decerr_lp;
            v_o      <= 1'b1;
            state_r  <= RESP;
          end else begin
            timer_r <= timer_inc;
          end
        end

        RESP: begin
          if (ready_and_i) begin
            v_o         <= 1'b0;
            ready_and_o <= 1'b1;
            state_r     <= IDLE;
          end
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_axil_dpi_initiator.sv
module tb_bsg_axil_dpi_initiator;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_i, ready_and_o, w_i;
  logic [31:0] addr_i, data_i;
  logic [3:0]  wstrb_i;
  logic        v_o, ready_and_i;
  logic [31:0] data_o;
  logic [1:0]  resp_o;
  logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i;
  logic [2:0]  awprot_o, arprot_o;
  logic [3:0]  wstrb_o;
  logic        awvalid_o, awready_i, wvalid_o, wready_i;
  logic [1:0]  bresp_i, rresp_i;
  logic        bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;

  always #5 clk = ~clk;

  bsg_axil_dpi_initiator #(
    .addr_width_p(32), .data_width_p(32), .timeout_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v_i), .ready_and_o(ready_and_o), .w_i(w_i), .addr_i(addr_i),
    .data_i(data_i), .wstrb_i(wstrb_i),
    .v_o(v_o), .ready_and_i(ready_and_i), .data_o(data_o), .resp_o(resp_o),
    .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly, w_dly, ar_dly, b_dly, r_dly, bp_dly;
    logic [1:0]  resp_in;
    logic [31:0] rdata;
    int          exp_a, exp_w, exp_lat;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  vec_t ra, wb;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sub();
    awready_i = 0; wready_i = 0; arready_i = 0; bvalid_i = 0; rvalid_i = 0;
    bresp_i = 0; rresp_i = 0; rdata_i = 0; ready_and_i = 0;
  endtask

  task automatic issue(input vec_t v);
    int   n;
    exp_t e;
    n = 0;
    while (ready_and_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ready_before_issue", 64'(ready_and_o), 64'(1));
    v_i = 1; w_i = v.w; addr_i = v.addr; data_i = v.data; wstrb_i = v.strb;
    tick();
    v_i = 0;
    e.data = v.exp_data;
    e.resp = v.exp_resp;
    sb.push_back(e);
  endtask

  // Subordinate model plus response consumer; cycle t=1 is the first cycle after accept.
  task automatic service(input vec_t v, input bit hold_next, input vec_t nxt);
    int   aw_c, w_c, ar_c, b_c, r_c, bp_c, lat, bad;
    bit   done;
    exp_t e;
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0; bp_c = 0; lat = -1; bad = 0; done = 0;
    for (int t = 1; t <= 80 && !done; t++) begin
      if (awvalid_o && awaddr_o !== v.addr) bad++;
      if (wvalid_o && (wdata_o !== v.data || wstrb_o !== v.strb)) bad++;
      if (arvalid_o && araddr_o !== v.addr) bad++;
      awready_i = awvalid_o && (aw_c == v.aw_dly);
      wready_i  = wvalid_o  && (w_c  == v.w_dly);
      arready_i = arvalid_o && (ar_c == v.ar_dly);
      bvalid_i  = bready_o  && (b_c  == v.b_dly);
      rvalid_i  = rready_o  && (r_c  == v.r_dly);
      bresp_i = v.resp_in; rresp_i = v.resp_in; rdata_i = v.rdata;
      if (awvalid_o) aw_c++;
      if (wvalid_o)  w_c++;
      if (arvalid_o) ar_c++;
      if (bready_o)  b_c++;
      if (rready_o)  r_c++;
      ready_and_i = 0;
      if (v_o) begin
        if (lat < 0) lat = t;
        if (data_o !== v.exp_data || resp_o !== v.exp_resp || ready_and_o !== 1'b0) bad++;
        if (hold_next) begin
          v_i = 1; w_i = nxt.w; addr_i = nxt.addr; data_i = nxt.data; wstrb_i = nxt.strb;
        end
        if (bp_c == v.bp_dly) begin
          ready_and_i = 1;
          done = 1;
          chk("scoreboard_nonempty", 64'(sb.size() != 0), 64'(1));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("data_o", 64'(data_o), 64'(e.data));
            chk("resp_o", 64'(resp_o), 64'(e.resp));
          end
        end
        bp_c++;
      end
      tick();
    end
    clear_sub();
    chk("response_seen", 64'(done), 64'(1));
    chk("latency", 64'(lat), 64'(v.exp_lat));
    chk("addr_valid_cycles", 64'(v.w ? aw_c : ar_c), 64'(v.exp_a));
    chk("wvalid_cycles", 64'(w_c), 64'(v.exp_w));
    chk("stable_outputs", 64'(bad), 64'(0));
  endtask

  initial begin
    int seen;
    //         w  addr      data          strb  aw w  ar   b    r bp resp    rdata          a w lat exp_data      exp_resp
    vecs[0] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0,   0,   0, 0, 2'b00, 32'h0,        1, 1, 3, 32'h0,        2'b00};
    vecs[1] = '{1, 32'h14, 32'hCAFEF00D, 4'h3, 0, 4, 0,   0,   0, 0, 2'b00, 32'h0,        1, 5, 7, 32'h0,        2'b00};
    vecs[2] = '{0, 32'h20, 32'h0,        4'h0, 0, 0, 2,   0,   0, 0, 2'b10, 32'h12345678, 3, 0, 5, 32'h12345678, 2'b10};
    vecs[3] = '{1, 32'h18, 32'h0000BEEF, 4'hC, 3, 1, 0,   2,   0, 1, 2'b10, 32'h0,        4, 2, 8, 32'h0,        2'b10};
    vecs[4] = '{0, 32'h24, 32'h0,        4'h0, 0, 0, 0,   0,   3, 0, 2'b00, 32'hA5A50F0F, 1, 0, 6, 32'hA5A50F0F, 2'b00};
    vecs[5] = '{0, 32'h30, 32'h0,        4'h0, 0, 0, 1000, 0,  0, 0, 2'b00, 32'hFFFFFFFF, 8, 0, 9, 32'h0,        2'b11};
    vecs[6] = '{1, 32'h34, 32'h00000055, 4'h1, 0, 0, 0,   1000, 0, 0, 2'b00, 32'h0,       1, 1, 10, 32'h0,       2'b11};
    vecs[7] = '{1, 32'h38, 32'h00000066, 4'h2, 0, 1000, 0, 0,  0, 0, 2'b00, 32'h0,        1, 8, 9, 32'h0,        2'b11};
    vecs[8] = '{0, 32'h3C, 32'h0,        4'h0, 0, 0, 1,   0,   1, 0, 2'b11, 32'h0F0F0F0F, 2, 0, 5, 32'h0F0F0F0F, 2'b11};
    ra      = '{0, 32'h28, 32'h0,        4'h0, 0, 0, 0,   0,   0, 5, 2'b00, 32'h0BADF00D, 1, 0, 3, 32'h0BADF00D, 2'b00};
    wb      = '{1, 32'h2C, 32'h11223344, 4'hF, 0, 0, 0,   0,   0, 0, 2'b00, 32'h0,        1, 1, 3, 32'h0,        2'b00};

    reset_i = 1; v_i = 0; w_i = 0; addr_i = 0; data_i = 0; wstrb_i = 0;
    clear_sub();
    repeat (3) tick();
    chk("reset_ready_and_o", 64'(ready_and_o), 64'(0));
    chk("reset_v_o", 64'(v_o), 64'(0));
    chk("reset_valids", 64'({awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}), 64'(0));
    chk("reset_data_resp", 64'({data_o, resp_o}), 64'(0));
    chk("prot", 64'({awprot_o, arprot_o}), 64'(0));
    reset_i = 0;
    tick();
    chk("ready_after_reset", 64'(ready_and_o), 64'(1));

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i]);
      service(vecs[i], 1'b0, vecs[i]);
    end

    // Response backpressure with a new command held on the input the whole time.
    issue(ra);
    service(ra, 1'b1, wb);
    chk("chain_v_o_dropped", 64'(v_o), 64'(0));
    chk("chain_ready_in_idle", 64'(ready_and_o), 64'(1));
    chk("chain_no_early_aw", 64'(awvalid_o), 64'(0));
    tick();
    v_i = 0;
    begin
      exp_t e;
      e.data = wb.exp_data;
      e.resp = wb.exp_resp;
      sb.push_back(e);
    end
    service(wb, 1'b0, wb);

    // Reset while waiting in WRESP.
    issue(vecs[0]);
    awready_i = 1; wready_i = 1;
    tick();
    clear_sub();
    chk("bready_before_reset", 64'(bready_o), 64'(1));
    reset_i = 1;
    bvalid_i = 1;
    tick();
    chk("midreset_valids", 64'({awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, v_o, ready_and_o}), 64'(0));
    chk("midreset_data_resp", 64'({data_o, resp_o}), 64'(0));
    chk("midreset_awaddr", 64'(awaddr_o), 64'(0));
    reset_i = 0;
    bvalid_i = 0;
    sb.delete();
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (v_o) seen++;
    end
    chk("no_resp_after_reset", 64'(seen), 64'(0));
    chk("ready_after_midreset", 64'(ready_and_o), 64'(1));
    issue(vecs[1]);
    service(vecs[1], 1'b0, vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
